dm_resp: RTL and testbench

- Data-memory responder: the memory end of the CPU load/store interface.
- Accepts word-aligned read/write requests from an initiator over a valid/ready request channel.
- Inserts a configurable number of wait states, applies byte-masked writes to an internal word array, and returns read data over a valid/ready response channel.
- Replaces the zero-latency data memory so the core can be run against realistic memory timing.

---
 rtl/dm_resp.sv | 119 +++++++++++
 tb/tb_dm_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one word-aligned load/store at a time, inserts
// WAIT_CYC wait states, applies byte-masked writes and returns read data.
module dm_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]            cnt;
  logic                  accept;
  logic                  we_q;
  logic                  err_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2-1:0] idx_q;

  logic [31:0] mem [DEPTH];

  // Misaligned byte addresses and anything beyond the array are rejected.
  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] upper;
    upper    = addr >> (DEPTH_LOG2 + 2);
    addr_err = (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    merge_bytes = res;
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYC == 0) ? ACCESS : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= 4'd0;
    else if (accept)         cnt <= 4'(WAIT_CYC);
    else if (state == WAIT)  cnt <= cnt - 4'd1;
  end

  // Request capture: later changes on req_* are ignored until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      err_q   <= addr_err(req_addr);
      be_q    <= req_be;
      wdata_q <= req_wdata;
      idx_q   <= req_addr[DEPTH_LOG2+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ACCESS) && we_q && !err_q)
      mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, be_q);
  end

  // Response registers hold their value through backpressure and clear on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_err   <= err_q;
      resp_rdata <= (err_q || we_q) ? 32'd0 : mem[idx_q];
    end else if ((state == RESP) && resp_ready) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: vector table, corner-case sequences, randomized traffic
// against a word-array model, and a zero-wait-state instance.
module tb_dm_resp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_z = 1'b0, req_we_z = 1'b0, resp_ready_z = 1'b0;
  logic [31:0] req_addr_z = 32'd0, req_wdata_z = 32'd0;
  logic [3:0]  req_be_z = 4'd0;
  logic        req_ready_z, resp_valid_z, resp_err_z, busy_z;
  logic [31:0] resp_rdata_z;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_we(req_we_z), .req_addr(req_addr_z), .req_be(req_be_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z), .resp_rdata(resp_rdata_z),
    .resp_err(resp_err_z), .busy(busy_z)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Full transaction on the WAIT_CYC=2 instance; starts and ends 1 ns after a rising edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output int lat);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
    lat = 0; n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      lat++; n++;
    end
    rd = resp_rdata; er = resp_err;
    if (!resp_valid) begin
      tests++; fails++;
      $display("FAIL txn_timeout: no response for addr %h", addr);
      lat = -1;
      return;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  vec_t        vt [15];
  logic [31:0] model [16];
  logic [31:0] rd, held;
  logic        er, we;
  int          lat, n;
  int          acc [16];
  int          rsp [16];
  logic [31:0] rdat [16];
  logic        rerr [16];
  int          na, nr;
  logic        prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h10,       4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,       4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,       4'h5, 32'h11223344, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDE22BE44, 1'b0};
    vt[4]  = '{1'b1, 32'h0,        4'hF, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 32'h13,       4'hF, 32'h0,        32'h0,        1'b1};
    vt[6]  = '{1'b1, 32'h1000,     4'hF, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[7]  = '{1'b0, 32'h0,        4'h0, 32'h0,        32'hA5A5A5A5, 1'b0};
    vt[8]  = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDE22BE44, 1'b0};
    vt[9]  = '{1'b1, 32'hFFC,      4'hF, 32'h12345678, 32'h0,        1'b0};
    vt[10] = '{1'b1, 32'hFFC,      4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    vt[11] = '{1'b0, 32'hFFC,      4'h0, 32'h0,        32'h12345678, 1'b0};
    vt[12] = '{1'b0, 32'h80000000, 4'h0, 32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 32'h12,       4'hF, 32'h77777777, 32'h0,        1'b1};
    vt[14] = '{1'b0, 32'h10,       4'h0, 32'h0,        32'hDE22BE44, 1'b0};

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    #20 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      txn(vt[i].we, vt[i].addr, vt[i].be, vt[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_idle_after", i), 32'(req_ready), 32'd1);
    end

    // Backpressure: response held for 5 cycles, a request pulse is refused.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    held = resp_rdata;
    check("bp_first_rdata", held, 32'hDE22BE44);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_rdata", k), resp_rdata, 32'hDE22BE44);
      check($sformatf("bp%0d_err", k), 32'(resp_err), 32'd0);
      check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      if (k == 2) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'h0;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_release_idle", 32'(req_ready), 32'd1);
    check("bp_release_valid", 32'(resp_valid), 32'd0);
    check("bp_release_rdata", resp_rdata, 32'd0);
    txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
    check("bp_pulse_ignored", rd, 32'hDE22BE44);

    // Reset while a write waits: write is discarded.
    txn(1'b1, 32'h20, 4'hF, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rw_busy_in_wait", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rw_req_ready", 32'(req_ready), 32'd1);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
    check("rw_discarded", rd, 32'h0);

    // Reset while the write response is pending: write is retained, response dropped.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_be = 4'hF; req_wdata = 32'h13572468;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("rr_valid_before", 32'(resp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rr_valid_dropped", 32'(resp_valid), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    txn(1'b0, 32'h24, 4'h0, 32'h0, rd, er, lat);
    check("rr_retained", rd, 32'h13572468);

    // Randomized traffic against a word-array model.
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      txn(1'b1, 32'h200 + 32'(4*w), 4'hF, model[w], rd, er, lat);
    end
    for (int t = 0; t < 150; t++) begin
      int sel, w;
      logic [31:0] addr, wd, exp_rd;
      logic [3:0]  be;
      logic        exp_er;
      sel = $urandom_range(0, 9);
      w   = $urandom_range(0, 15);
      we  = 1'($urandom);
      be  = 4'($urandom);
      wd  = $urandom;
      if (sel <= 6)      addr = 32'h200 + 32'(4*w);
      else if (sel == 7) addr = 32'h200 + 32'(4*w) + 32'($urandom_range(1, 3));
      else if (sel == 8) addr = ($urandom | 32'h1000) & 32'hFFFFFFFC;
      else               addr = $urandom | 32'h1001;
      exp_er = (addr % 4 != 0) || (addr >= 32'd4096);
      exp_rd = 32'h0;
      if (!exp_er) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) model[w][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_rd = model[w];
        end
      end
      txn(we, addr, be, wd, rd, er, lat);
      check($sformatf("rnd%0d_rdata@%h", t, addr), rd, exp_rd);
      check($sformatf("rnd%0d_err@%h", t, addr), 32'(er), 32'(exp_er));
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'd3);
    end

    // Zero wait states: write then back-to-back reads with resp_ready held high.
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 32'h40; req_be_z = 4'hF;
    req_wdata_z = 32'h600DCAFE; resp_ready_z = 1'b1;
    na = 0; nr = 0;
    for (int c = 0; c < 14; c++) begin
      prev = req_ready_z;
      @(posedge clk); #1;
      if (prev) begin acc[na] = c; na++; end
      if (c == 0) req_we_z = 1'b0;
      if (resp_valid_z) begin
        rsp[nr] = c; rdat[nr] = resp_rdata_z; rerr[nr] = resp_err_z; nr++;
      end
    end
    req_valid_z = 1'b0; resp_ready_z = 1'b0;
    check("z_accept_count", 32'(na), 32'd5);
    check("z_resp_count", 32'(nr), 32'd5);
    for (int k = 0; k < na - 1; k++)
      check($sformatf("z_spacing%0d", k), 32'(acc[k+1] - acc[k]), 32'd3);
    for (int k = 0; k < nr && k < na; k++) begin
      check($sformatf("z_latency%0d", k), 32'(rsp[k] - acc[k]), 32'd1);
      check($sformatf("z_rdata%0d", k), rdat[k], (k == 0) ? 32'h0 : 32'h600DCAFE);
      check($sformatf("z_err%0d", k), 32'(rerr[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
